// File: rtl/srl_pkg.sv
// Shared types and constants for the set/reset latch pulse controller.
package srl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OP_SET = 1'b0,
        OP_CLR = 1'b1
    } op_t;

    localparam int unsigned CNT_W       = 4;
    localparam int unsigned PULSE_W_DEF = 2;
    localparam int unsigned GAP_W_DEF   = 1;

endpackage

// File: rtl/srl_ctrl_pulse_timer.sv
// Loadable down-counter shared by the PULSE and GAP phases; holds at zero.
module pulse_timer
    import srl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign zero_c = (count_q == '0);

endmodule

// File: rtl/srl_ctrl.sv
// Drives an external S/R latch with timed active-low pulses and checks its feedback.
module srl_ctrl
    import srl_pkg::*;
#(
    parameter int unsigned PULSE_W = PULSE_W_DEF,
    parameter int unsigned GAP_W   = GAP_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    input  logic q_fb,
    output logic s_n,
    output logic r_n,
    output logic set_ack,
    output logic clr_ack,
    output logic busy,
    output logic done,
    output logic err
);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    op_t              last_q, last_d;
    op_t              pick;
    logic             s_n_d, r_n_d, set_ack_d, clr_ack_d, done_d, err_d;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0] tmr_val;

    pulse_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(tmr_val),
        .dec     (tmr_dec),
        .zero_c  (tmr_zero)
    );

    // Round-robin on contention: the op not granted last time wins.
    always_comb begin
        if (set_req && clr_req) begin
            pick = (last_q == OP_CLR) ? OP_SET : OP_CLR;
        end else begin
            pick = set_req ? OP_SET : OP_CLR;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        last_d    = last_q;
        s_n_d     = 1'b1;
        r_n_d     = 1'b1;
        set_ack_d = 1'b0;
        clr_ack_d = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        tmr_val   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (set_req || clr_req) begin
                    state_d   = ST_PULSE;
                    op_d      = pick;
                    last_d    = pick;
                    tmr_load  = 1'b1;
                    tmr_val   = CNT_W'(PULSE_W - 1);
                    set_ack_d = (pick == OP_SET);
                    clr_ack_d = (pick == OP_CLR);
                    s_n_d     = (pick != OP_SET);
                    r_n_d     = (pick != OP_CLR);
                end
            end
            ST_PULSE: begin
                if (tmr_zero) begin
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(GAP_W - 1);
                end else begin
                    tmr_dec = 1'b1;
                    s_n_d   = (op_q != OP_SET);
                    r_n_d   = (op_q != OP_CLR);
                end
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = (op_q == OP_SET) ? ~q_fb : q_fb;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and all outputs registered together so outputs track state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_SET;
            last_q  <= OP_CLR;
            s_n     <= 1'b1;
            r_n     <= 1'b1;
            set_ack <= 1'b0;
            clr_ack <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            last_q  <= last_d;
            s_n     <= s_n_d;
            r_n     <= r_n_d;
            set_ack <= set_ack_d;
            clr_ack <= clr_ack_d;
            busy    <= (state_d != ST_IDLE);
            done    <= done_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_srl_ctrl.sv
// Directed bench for srl_ctrl driving a behavioural NAND S/R latch model.
module tb_srl_ctrl;
    import srl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;
    logic q_fb;
    logic s_n, r_n, set_ack, clr_ack, busy, done, err;

    logic q_lat = 1'b0;
    logic force_en = 1'b0;
    logic force_val = 1'b0;
    logic mon_en = 1'b0;

    int checks = 0;
    int errors = 0;

    // Packed order: s_n r_n set_ack clr_ack busy done err
    logic [6:0] obs;

    srl_ctrl #(.PULSE_W(2), .GAP_W(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .set_req(set_req),
        .clr_req(clr_req),
        .q_fb   (q_fb),
        .s_n    (s_n),
        .r_n    (r_n),
        .set_ack(set_ack),
        .clr_ack(clr_ack),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    always @(s_n or r_n) begin
        if (!s_n) q_lat = 1'b1;
        else if (!r_n) q_lat = 1'b0;
    end

    assign q_fb = force_en ? force_val : q_lat;
    assign obs  = {s_n, r_n, set_ack, clr_ack, busy, done, err};

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (!s_n && !r_n) begin
                errors++;
                $display("FAIL mon_both_low s_n=%b r_n=%b required not both 0", s_n, r_n);
            end
            checks++;
            if (busy !== (dut.state_q != ST_IDLE)) begin
                errors++;
                $display("FAIL mon_busy busy=%b required %b", busy, dut.state_q != ST_IDLE);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        mon_en = 1'b1;
        checks++;
        if (obs !== 7'b1100000) begin
            errors++;
            $display("FAIL reset_outs got %b required %b", obs, 7'b1100000);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obs !== 7'b1100000) begin
            errors++;
            $display("FAIL reset_idle got %b required %b", obs, 7'b1100000);
        end
    endtask

    task automatic test_single_set();
        set_req = 1'b1;
        tick();
        checks++;
        if (obs !== 7'b0110100) begin errors++; $display("FAIL set_c1 got %b required %b", obs, 7'b0110100); end
        set_req = 1'b0;
        tick();
        checks++;
        if (obs !== 7'b0100100) begin errors++; $display("FAIL set_c2 got %b required %b", obs, 7'b0100100); end
        tick();
        checks++;
        if (obs !== 7'b1100100) begin errors++; $display("FAIL set_gap got %b required %b", obs, 7'b1100100); end
        tick();
        checks++;
        if (obs !== 7'b1100110) begin errors++; $display("FAIL set_done got %b required %b", obs, 7'b1100110); end
        checks++;
        if (q_fb !== 1'b1) begin errors++; $display("FAIL set_q got %b required 1", q_fb); end
        tick();
        checks++;
        if (obs !== 7'b1100000) begin errors++; $display("FAIL set_idle got %b required %b", obs, 7'b1100000); end
    endtask

    // Last grant was a set, so contention must go to clear.
    task automatic test_rr_after_set();
        set_req = 1'b1;
        clr_req = 1'b1;
        tick();
        checks++;
        if (obs !== 7'b1001100) begin errors++; $display("FAIL rr_grant got %b required %b", obs, 7'b1001100); end
        set_req = 1'b0;
        clr_req = 1'b0;
        tick();
        checks++;
        if (obs !== 7'b1000100) begin errors++; $display("FAIL rr_c2 got %b required %b", obs, 7'b1000100); end
        tick();
        tick();
        checks++;
        if (obs !== 7'b1100110) begin errors++; $display("FAIL rr_done got %b required %b", obs, 7'b1100110); end
        checks++;
        if (q_fb !== 1'b0) begin errors++; $display("FAIL rr_q got %b required 0", q_fb); end
        tick();
    endtask

    task automatic test_both_from_reset();
        rst = 1'b1;
        set_req = 1'b1;
        clr_req = 1'b1;
        tick();
        tick();
        checks++;
        if (obs !== 7'b1100000) begin errors++; $display("FAIL both_rst_prio got %b required %b", obs, 7'b1100000); end
        rst = 1'b0;
        tick();
        checks++;
        if (obs !== 7'b0110100) begin errors++; $display("FAIL both_set_first got %b required %b", obs, 7'b0110100); end
        set_req = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (obs !== 7'b1100110) begin errors++; $display("FAIL both_set_done got %b required %b", obs, 7'b1100110); end
        tick();
        checks++;
        if (obs !== 7'b1100000) begin errors++; $display("FAIL both_idle_gap got %b required %b", obs, 7'b1100000); end
        tick();
        checks++;
        if (obs !== 7'b1001100) begin errors++; $display("FAIL both_clr_ack got %b required %b", obs, 7'b1001100); end
        clr_req = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (obs !== 7'b1100110) begin errors++; $display("FAIL both_clr_done got %b required %b", obs, 7'b1100110); end
        checks++;
        if (q_fb !== 1'b0) begin errors++; $display("FAIL both_q got %b required 0", q_fb); end
        tick();
    endtask

    task automatic test_feedback_err();
        force_en = 1'b1;
        force_val = 1'b0;
        set_req = 1'b1;
        tick();
        set_req = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (obs !== 7'b1100111) begin errors++; $display("FAIL err_done got %b required %b", obs, 7'b1100111); end
        tick();
        checks++;
        if (obs !== 7'b1100000) begin errors++; $display("FAIL err_clears got %b required %b", obs, 7'b1100000); end
        force_en = 1'b0;
        clr_req = 1'b1;
        tick();
        checks++;
        if (obs !== 7'b1001100) begin errors++; $display("FAIL err_next_ack got %b required %b", obs, 7'b1001100); end
        clr_req = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (obs !== 7'b1100110) begin errors++; $display("FAIL err_next_done got %b required %b", obs, 7'b1100110); end
        tick();
    endtask

    task automatic test_rst_abort();
        set_req = 1'b1;
        tick();
        set_req = 1'b0;
        tick();
        checks++;
        if (obs !== 7'b0100100) begin errors++; $display("FAIL abort_pulse2 got %b required %b", obs, 7'b0100100); end
        rst = 1'b1;
        tick();
        checks++;
        if (obs !== 7'b1100000) begin errors++; $display("FAIL abort_drive got %b required %b", obs, 7'b1100000); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs !== 7'b1100000) begin errors++; $display("FAIL abort_quiet%0d got %b required %b", i, obs, 7'b1100000); end
        end
        set_req = 1'b1;
        tick();
        checks++;
        if (obs !== 7'b0110100) begin errors++; $display("FAIL abort_new_ack got %b required %b", obs, 7'b0110100); end
        set_req = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (obs !== 7'b1100110) begin errors++; $display("FAIL abort_new_done got %b required %b", obs, 7'b1100110); end
        tick();
    endtask

    task automatic test_busy_ignore();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        set_req = 1'b1;
        tick();
        set_req = 1'b0;
        checks++;
        if (obs !== 7'b1100100) begin errors++; $display("FAIL busy_gap got %b required %b", obs, 7'b1100100); end
        tick();
        checks++;
        if (obs !== 7'b1100110) begin errors++; $display("FAIL busy_done got %b required %b", obs, 7'b1100110); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== 7'b1100000) begin errors++; $display("FAIL busy_no_extra%0d got %b required %b", i, obs, 7'b1100000); end
        end
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_rr_after_set();
        test_both_from_reset();
        test_feedback_err();
        test_rst_abort();
        test_busy_ignore();
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
